// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store controller in front of DataMemory. Accepts CPU load/store
//   requests over a valid/ready handshake and absorbs the memory's 1-cycle
//   read latency. It also sequences 16-word context save (regfile -> mem)
//   and restore (mem -> regfile) through the reserved words 0..CTX_WORDS-1.
//   CPU requests that target the reserved words get resp_err and no access.
// Ports
//   clk, rst                  clock, async active-high reset
//   req_*                     CPU request handshake and payload
//   resp_*                    1-cycle response pulse with load data / error
//   ctx_save, ctx_restore     context operation start pulses (IDLE only)
//   ctx_busy, ctx_done        context operation status
//   reg_idx/rdata/we/wdata    regfile access port
//   mem_*                     DataMemory port
module mem_access_unit #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned MEM_ADDR_BITS = 8,
    parameter int unsigned CTX_WORDS     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [MEM_ADDR_BITS-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]     req_wdata,
    output logic                     resp_valid,
    output logic [WORD_SIZE-1:0]     resp_rdata,
    output logic                     resp_err,
    input  logic                     ctx_save,
    input  logic                     ctx_restore,
    output logic                     ctx_busy,
    output logic                     ctx_done,
    output logic [3:0]               reg_idx,
    input  logic [WORD_SIZE-1:0]     reg_rdata,
    output logic                     reg_we,
    output logic [WORD_SIZE-1:0]     reg_wdata,
    output logic                     mem_write_en,
    output logic                     mem_read_en,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    input  logic [WORD_SIZE-1:0]     mem_read_data
);

    localparam logic [MEM_ADDR_BITS-1:0] CtxLimit = MEM_ADDR_BITS'(CTX_WORDS);
    localparam logic [4:0]               CntLast  = 5'(CTX_WORDS - 1);
    // Restore runs one extra cycle to write back the last read word.
    localparam logic [4:0]               CntRestLast = 5'(CTX_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StResp,
        StSave,
        StRestore,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic                     wr_q, wr_d;
    logic                     err_q, err_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]     wdata_q, wdata_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (ctx_save) begin
                    state_d = StSave;
                    cnt_d   = '0;
                end else if (ctx_restore) begin
                    state_d = StRestore;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = (req_addr < CtxLimit);
                    // Reserved-region hits skip the memory access entirely.
                    state_d = (req_addr < CtxLimit) ? StResp : StAccess;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            StSave: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StRestore: begin
                if (cnt_q == CntRestLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_err       = 1'b0;
        ctx_busy       = 1'b0;
        ctx_done       = 1'b0;
        reg_idx        = '0;
        reg_we         = 1'b0;
        reg_wdata      = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        unique case (state_q)
            // Gate with rst so every output reads 0 while reset is held.
            StIdle: req_ready = ~rst;
            StAccess: begin
                mem_addr       = addr_q;
                mem_write_en   = wr_q;
                mem_read_en    = ~wr_q;
                mem_write_data = wr_q ? wdata_q : '0;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (wr_q || err_q) ? '0 : mem_read_data;
            end
            StSave: begin
                ctx_busy       = 1'b1;
                reg_idx        = cnt_q[3:0];
                mem_write_en   = 1'b1;
                mem_addr       = MEM_ADDR_BITS'(cnt_q);
                mem_write_data = reg_rdata;
            end
            StRestore: begin
                ctx_busy = 1'b1;
                if (cnt_q <= CntLast) begin
                    mem_read_en = 1'b1;
                    mem_addr    = MEM_ADDR_BITS'(cnt_q);
                end
                // Read data for word cnt-1 arrives this cycle.
                reg_we    = (cnt_q != 5'd0);
                reg_idx   = 4'(cnt_q - 5'd1);
                reg_wdata = mem_read_data;
            end
            StDone: ctx_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural DataMemory and regfile around the
// DUT, scoreboard queues for responses, memory writes and regfile writes.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata;
    logic        ctx_save, ctx_restore, ctx_busy, ctx_done;
    logic [3:0]  reg_idx;
    logic [15:0] reg_rdata, reg_wdata;
    logic        reg_we;
    logic        mem_write_en, mem_read_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_write_data, mem_read_data;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ctx_save       (ctx_save),
        .ctx_restore    (ctx_restore),
        .ctx_busy       (ctx_busy),
        .ctx_done       (ctx_done),
        .reg_idx        (reg_idx),
        .reg_rdata      (reg_rdata),
        .reg_we         (reg_we),
        .reg_wdata      (reg_wdata),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // External models: synchronous-read DataMemory and combinational-read regfile
    logic [15:0] mem [256];
    logic [15:0] rf  [16];
    logic [15:0] mem_rd;
    assign mem_read_data = mem_rd;
    assign reg_rdata     = rf[reg_idx];

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_write_data;
        if (mem_read_en)  mem_rd <= mem[mem_addr];
        if (reg_we)       rf[reg_idx] <= reg_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    typedef struct packed {logic [15:0] data; logic err; int cyc;} rsp_t;
    typedef struct packed {logic [7:0] addr; logic [15:0] data; int cyc;} wr_t;
    typedef struct packed {logic [3:0] idx; logic [15:0] data; int cyc;} rw_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    rw_t  rw_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [67:0] all_out;
    assign all_out = {req_ready, resp_valid, resp_rdata, resp_err, ctx_busy, ctx_done,
                      reg_idx, reg_we, reg_wdata, mem_write_en, mem_read_en, mem_addr,
                      mem_write_data};

    // Scoreboard monitors, sampled on the falling edge
    rsp_t er;
    wr_t  ew;
    rw_t  eg;
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                chk("resp_expected", 32'(rsp_q.size() > 0), 1);
                if (rsp_q.size() > 0) begin
                    er = rsp_q.pop_front();
                    chk("resp_cycle", cyc, er.cyc);
                    chk("resp_rdata", 32'(resp_rdata), 32'(er.data));
                    chk("resp_err", 32'(resp_err), 32'(er.err));
                end
            end
            if (mem_write_en) begin
                chk("memwr_expected", 32'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    ew = wr_q.pop_front();
                    chk("memwr_cycle", cyc, ew.cyc);
                    chk("memwr_addr", 32'(mem_addr), 32'(ew.addr));
                    chk("memwr_data", 32'(mem_write_data), 32'(ew.data));
                end
            end
            if (reg_we) begin
                chk("regwr_expected", 32'(rw_q.size() > 0), 1);
                if (rw_q.size() > 0) begin
                    eg = rw_q.pop_front();
                    chk("regwr_cycle", cyc, eg.cyc);
                    chk("regwr_idx", 32'(reg_idx), 32'(eg.idx));
                    chk("regwr_data", 32'(reg_wdata), 32'(eg.data));
                end
            end
            if (mem_read_en) rd_cnt++;
            if (ctx_done)    done_cnt++;
        end
    end

    // One CPU request issued from IDLE; err responses come one cycle earlier.
    task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] exp_data, input logic exp_err);
        int k;
        @(posedge clk); #1;
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        k = cyc + 1;
        rsp_q.push_back('{data: exp_data, err: exp_err, cyc: (exp_err ? k : k + 1)});
        if (w && !exp_err) wr_q.push_back('{addr: a, data: d, cyc: k});
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    int k, k2, d0, r0;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        ctx_save = 1'b0; ctx_restore = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        for (int i = 0; i < 16; i++) rf[i] <= '0;
        mem_rd <= '0;
        repeat (2) @(posedge clk); #1;
        chk("reset_outputs_zero", 32'(all_out != 0), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 1);
        chk("post_reset_busy", 32'(ctx_busy), 0);

        // Store then load a normal word
        send(1'b1, 8'h20, 16'hBEEF, 16'h0000, 1'b0);
        send(1'b0, 8'h20, 16'h0000, 16'hBEEF, 1'b0);

        // Reserved-region load: error, no memory access
        r0 = rd_cnt;
        send(1'b0, 8'h05, 16'h0000, 16'h0000, 1'b1);
        chk("err_no_read", rd_cnt, r0);

        // Context save
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rf[i] <= 16'(16'h1000 + i);
        d0 = done_cnt;
        ctx_save = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 16; i++) wr_q.push_back('{addr: 8'(i), data: 16'(16'h1000 + i),
                                                       cyc: k + i});
        @(posedge clk); #1;
        ctx_save = 1'b0;
        @(negedge clk);
        chk("save_busy", 32'(ctx_busy), 1);
        repeat (16) @(negedge clk);
        chk("save_done_cycle", 32'(ctx_done), 1);
        chk("save_busy_end", 32'(ctx_busy), 0);
        @(negedge clk);
        chk("save_done_pulse", 32'(ctx_done), 0);
        chk("save_ready_after", 32'(req_ready), 1);
        chk("save_done_count", done_cnt, d0 + 1);

        // Context restore into a cleared regfile
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rf[i] <= '0;
        d0 = done_cnt;
        ctx_restore = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 16; i++) rw_q.push_back('{idx: 4'(i), data: 16'(16'h1000 + i),
                                                       cyc: k + 1 + i});
        @(posedge clk); #1;
        ctx_restore = 1'b0;
        repeat (18) @(negedge clk);
        chk("restore_done_cycle", 32'(ctx_done), 1);
        @(negedge clk);
        chk("restore_done_count", done_cnt, d0 + 1);
        chk("restore_rf0", 32'(rf[0]), 32'h1000);
        chk("restore_rf15", 32'(rf[15]), 32'h100F);

        // Simultaneous save/restore/request: save wins, request waits
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rf[i] <= 16'(16'h2000 + i);
        d0 = done_cnt;
        ctx_save = 1'b1; ctx_restore = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 16'h1234;
        k = cyc + 1;
        for (int i = 0; i < 16; i++) wr_q.push_back('{addr: 8'(i), data: 16'(16'h2000 + i),
                                                       cyc: k + i});
        @(posedge clk); #1;
        ctx_save = 1'b0; ctx_restore = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("held_req_ready", 32'(req_ready), 1);
        k2 = cyc + 1;
        chk("held_req_accept_cycle", k2, k + 18);
        wr_q.push_back('{addr: 8'h40, data: 16'h1234, cyc: k2});
        rsp_q.push_back('{data: 16'h0000, err: 1'b0, cyc: k2 + 1});
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        chk("prio_done_count", done_cnt, d0 + 1);

        // Reset in the middle of a save at cnt=7
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rf[i] <= 16'(16'h3000 + i);
        ctx_save = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 8; i++) wr_q.push_back('{addr: 8'(i), data: 16'(16'h3000 + i),
                                                      cyc: k + i});
        @(posedge clk); #1;
        ctx_save = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midsave_reset_outputs_zero", 32'(all_out != 0), 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("midsave_ready_after", 32'(req_ready), 1);
        chk("midsave_busy_after", 32'(ctx_busy), 0);
        repeat (20) @(negedge clk);
        chk("midsave_no_done", done_cnt, d0);
        chk("midsave_word6_written", 32'(mem[6]), 32'h3006);
        chk("midsave_word7_untouched", 32'(mem[7]), 32'h2007);

        // Normal operation resumes
        send(1'b0, 8'h40, 16'h0000, 16'h1234, 1'b0);

        chk("resp_queue_drained", rsp_q.size(), 0);
        chk("memwr_queue_drained", wr_q.size(), 0);
        chk("regwr_queue_drained", rw_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
